// File: rtl/ltch_ctrl_pkg.sv
// Shared types and constants for the latch register-file write controller.
package ltch_ctrl_pkg;

  localparam int unsigned MAX_REQ_NUM = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_WRITE = 2'd2,
    ST_HOLD  = 2'd3
  } ltch_state_e;

endpackage

// File: rtl/ltch_rf_wr_ctrl_chk.sv
// Simulation-only protocol checks for the latch write controller.
module ltch_rf_wr_ctrl_chk #(
  parameter int REQ_NUM = 2,
  parameter int DEPTH   = 16,
  parameter int DW      = 32
) (
  input logic               clk,
  input logic               rst_n,
  input logic [REQ_NUM-1:0] req_valid,
  input logic [DEPTH-1:0]   ltch_lden,
  input logic [DW-1:0]      ltch_dnxt
);

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
  a_lden_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ltch_lden))
    else $error("ltch_lden has more than one bit set: 0x%0h", ltch_lden);

  // Data must be steady while an enable is open and for one cycle after it closes.
  a_dnxt_stable : assert property (@(posedge clk) disable iff (!rst_n)
    ((ltch_lden != '0) || ($past(ltch_lden) != '0)) |-> $stable(ltch_dnxt))
    else $error("ltch_dnxt changed around an enable pulse");

  a_valid_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(req_valid))
    else $fatal(1, "req_valid is unknown after reset");
`endif
`endif

endmodule

// File: rtl/ltch_rr_arb.sv
// Combinational round-robin arbiter: search starts at ptr_i+1 and wraps modulo REQ_NUM.
module ltch_rr_arb #(
  parameter int REQ_NUM = 2,
  parameter int PW      = 1
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [REQ_NUM-1:0] gnt_o,
  output logic [PW-1:0]      gnt_idx_o
);

  // Walk candidates in priority order; the first requesting one wins.
  always_comb begin
    logic found;
    int   cand;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      cand = (int'(ptr_i) + k) % REQ_NUM;
      for (int i = 0; i < REQ_NUM; i++) begin
        if (!found && (cand == i) && req_i[i]) begin
          found     = 1'b1;
          gnt_o[i]  = 1'b1;
          gnt_idx_o = PW'(i);
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/ltch_rf_wr_ctrl.sv
// Write sequencer for an external latch array: round-robin grant, staged data and
// a registered one-hot latch enable bracketed by SETUP and HOLD cycles.
module ltch_rf_wr_ctrl
  import ltch_ctrl_pkg::*;
#(
  parameter int REQ_NUM = 2,
  parameter int DEPTH   = 16,
  parameter int DW      = 32,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REQ_NUM-1:0]    req_valid,
  output logic [REQ_NUM-1:0]    req_ready,
  input  logic [REQ_NUM*AW-1:0] req_addr,
  input  logic [REQ_NUM*DW-1:0] req_data,
  output logic [DEPTH-1:0]      ltch_lden,
  output logic [DW-1:0]         ltch_dnxt,
  output logic                  busy,
  output logic [AW-1:0]         busy_addr
);

  localparam int            PW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [PW-1:0] PTR_RST = PW'(REQ_NUM - 1);

  ltch_state_e        state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [DW-1:0]      data_q, data_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [DEPTH-1:0]   lden_q, lden_d;
  logic               busy_q, busy_d;
  logic [REQ_NUM-1:0] gnt_s;
  logic [PW-1:0]      gnt_idx_s;
  logic               win_open_s;
  logic               accept_s;
  logic [DW-1:0]      sel_data_s;
  logic [AW-1:0]      sel_addr_s;

  ltch_rr_arb #(
    .REQ_NUM (REQ_NUM),
    .PW      (PW)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt_s),
    .gnt_idx_o (gnt_idx_s)
  );

  // Accept window plus a one-hot AND-OR select of the winner's payload.
  always_comb begin
    win_open_s = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    accept_s   = win_open_s && (|gnt_s);
    req_ready  = win_open_s ? gnt_s : '0;
    sel_data_s = '0;
    sel_addr_s = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      sel_data_s = sel_data_s | ({DW{gnt_s[i]}} & req_data[i*DW +: DW]);
      sel_addr_s = sel_addr_s | ({AW{gnt_s[i]}} & req_addr[i*AW +: AW]);
    end
  end

  // Sequencer next state; the enable is decoded from the already-stable address flop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = accept_s ? ST_SETUP : ST_IDLE;
      ST_SETUP: state_d = ST_WRITE;
      ST_WRITE: state_d = ST_HOLD;
      ST_HOLD:  state_d = accept_s ? ST_SETUP : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (accept_s) begin
      ptr_d  = gnt_idx_s;
      data_d = sel_data_s;
      addr_d = sel_addr_s;
    end else begin
      ptr_d  = ptr_q;
      data_d = data_q;
      addr_d = addr_q;
    end

    busy_d = (state_d != ST_IDLE);

    // Addresses at or beyond DEPTH match no entry, so the pulse is simply absent.
    lden_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      lden_d[e] = (state_d == ST_WRITE) && (addr_q == AW'(e));
    end
  end

  // State, pointer and output flops; the enable clears asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      data_q  <= '0;
      addr_q  <= '0;
      lden_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      lden_q  <= lden_d;
      busy_q  <= busy_d;
    end
  end

  assign ltch_lden = lden_q;
  assign ltch_dnxt = data_q;
  assign busy      = busy_q;
  assign busy_addr = addr_q;

`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
  ltch_rf_wr_ctrl_chk #(
    .REQ_NUM (REQ_NUM),
    .DEPTH   (DEPTH),
    .DW      (DW)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .ltch_lden (lden_q),
    .ltch_dnxt (data_q)
  );
`endif
`endif

endmodule

// File: tb/tb_ltch_rf_wr_ctrl.sv
// Bench: a 16-entry and a 12-entry controller share one set of requesters; an
// age-based transaction model checks both every cycle, directed checks pin the model.
module tb_ltch_rf_wr_ctrl;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [7:0]  req_addr  = '0;
  logic [63:0] req_data  = '0;

  logic [1:0]  r16, r12;
  logic [15:0] l16;
  logic [11:0] l12;
  logic [31:0] d16, d12;
  logic        b16, b12;
  logic [3:0]  ba16, ba12;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ltch_rf_wr_ctrl #(.REQ_NUM(2), .DEPTH(16), .DW(32)) dut16 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r16),
    .req_addr(req_addr), .req_data(req_data), .ltch_lden(l16),
    .ltch_dnxt(d16), .busy(b16), .busy_addr(ba16));

  ltch_rf_wr_ctrl #(.REQ_NUM(2), .DEPTH(12), .DW(32)) dut12 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r12),
    .req_addr(req_addr), .req_data(req_data), .ltch_lden(l12),
    .ltch_dnxt(d12), .busy(b12), .busy_addr(ba12));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: age counts cycles since the accepting edge (1=setup, 2=pulse, 3=hold).
  int          m_ptr  = 1;
  bit          m_busy = 1'b0;
  int          m_age  = 0;
  int          m_addr = 0;
  logic [31:0] m_dnxt = '0;

  always @(negedge clk) begin
    int          win;
    logic [1:0]  e_rdy;
    logic [15:0] e16;
    logic [11:0] e12;
    if (!rst_n) begin
      m_ptr = 1; m_busy = 1'b0; m_age = 0; m_addr = 0; m_dnxt = '0;
      chk("m_rst_lden16", 64'(l16), 64'd0);
      chk("m_rst_lden12", 64'(l12), 64'd0);
      chk("m_rst_busy",   64'({b16, b12}), 64'd0);
      chk("m_rst_dnxt",   64'({d16, d12}), 64'd0);
      chk("m_rst_baddr",  64'({ba16, ba12}), 64'd0);
    end else begin
      win = -1;
      if (!m_busy || m_age == 3) begin
        for (int k = 1; k <= 2; k++) begin
          int j;
          j = (m_ptr + k) % 2;
          if (win < 0 && req_valid[j]) win = j;
        end
      end
      e_rdy = '0;
      if (win >= 0) e_rdy[win] = 1'b1;
      e16 = (m_busy && m_age == 2) ? 16'(32'd1 << m_addr) : 16'd0;
      e12 = (m_busy && m_age == 2 && m_addr < 12) ? 12'(32'd1 << m_addr) : 12'd0;
      chk("m_ready16", 64'(r16), 64'(e_rdy));
      chk("m_ready12", 64'(r12), 64'(e_rdy));
      chk("m_lden16",  64'(l16), 64'(e16));
      chk("m_lden12",  64'(l12), 64'(e12));
      chk("m_dnxt16",  64'(d16), 64'(m_dnxt));
      chk("m_dnxt12",  64'(d12), 64'(m_dnxt));
      chk("m_busy",    64'({b16, b12}), {62'd0, m_busy, m_busy});
      chk("m_baddr16", 64'(ba16), 64'(m_addr));
      chk("m_baddr12", 64'(ba12), 64'(m_addr));
      if (win >= 0) begin
        m_busy = 1'b1; m_age = 1; m_ptr = win;
        m_addr = int'(req_addr[win*4 +: 4]);
        m_dnxt = req_data[win*32 +: 32];
      end else if (m_busy) begin
        m_age++;
        if (m_age > 3) begin m_busy = 1'b0; m_age = 0; end
      end
    end
  end

  task automatic go();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0;
    @(posedge clk); #2; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    chk("rst_lden", 64'(l16), 64'd0);
    chk("rst_busy", 64'(b16), 64'd0);

    // Single write from req0
    go(); req_valid = 2'b01; req_addr = {4'd0, 4'd3}; req_data = {32'h0, 32'hDEADBEEF};
    mid(); chk("sw_ready_c0", 64'(r16), 64'h1);
    go(); req_valid = '0;
    mid(); chk("sw_lden_c1", 64'(l16), 64'h0); chk("sw_dnxt_c1", 64'(d16), 64'hDEADBEEF);
           chk("sw_busy_c1", 64'(b16), 64'h1);
    mid(); chk("sw_lden_c2", 64'(l16), 64'h0008); chk("sw_dnxt_c2", 64'(d16), 64'hDEADBEEF);
    mid(); chk("sw_lden_c3", 64'(l16), 64'h0); chk("sw_dnxt_c3", 64'(d16), 64'hDEADBEEF);
           chk("sw_busy_c3", 64'(b16), 64'h1);
    mid(); chk("sw_busy_c4", 64'(b16), 64'h0);

    // Contention after reset: 0,1,0,1 every three cycles with no idle gap
    do_reset();
    go(); req_valid = 2'b11; req_addr = {4'd2, 4'd1}; req_data = {32'h2222_1111, 32'h1111_2222};
    for (int k = 0; k < 12; k++) begin
      mid();
      if (k % 3 == 0) chk("ct_ready", 64'(r16), ((k / 3) % 2 == 1) ? 64'h2 : 64'h1);
      if (k % 3 == 2) chk("ct_lden", 64'(l16), ((k / 3) % 2 == 1) ? 64'h0004 : 64'h0002);
      if (k > 0) chk("ct_busy", 64'(b16), 64'h1);
      if (k == 9) begin go(); req_valid = '0; end
    end
    repeat (3) mid();

    // Back-to-back: req1 shows up during HOLD
    go(); req_valid = 2'b01; req_addr = {4'd5, 4'd7}; req_data = {32'hB2B2_0005, 32'hA1A1_0007};
    mid(); chk("bb_ready0", 64'(r16), 64'h1);
    go(); req_valid = '0;
    mid();
    mid(); chk("bb_lden0", 64'(l16), 64'h0080);
    go(); req_valid = 2'b10;
    mid(); chk("bb_ready_hold", 64'(r16), 64'h2); chk("bb_busy_hold", 64'(b16), 64'h1);
    go(); req_valid = '0;
    mid(); chk("bb_busy_gap", 64'(b16), 64'h1);
    mid(); chk("bb_lden1", 64'(l16), 64'h0020); chk("bb_dnxt1", 64'(d16), 64'hB2B2_0005);
    mid(); chk("bb_lden1_off", 64'(l16), 64'h0);
    mid(); chk("bb_idle", 64'(b16), 64'h0);

    // Out-of-range address on the 12-entry instance
    go(); req_valid = 2'b01; req_addr = {4'd0, 4'd13}; req_data = {32'h0, 32'h1313_1313};
    mid(); chk("oor_ready", 64'(r12), 64'h1);
    go(); req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      mid();
      chk("oor_lden12", 64'(l12), 64'h0);
      chk("oor_busy12", 64'(b12), 64'h1);
      chk("oor_baddr12", 64'(ba12), 64'd13);
      if (k == 2) chk("oor_lden16", 64'(l16), 64'h2000);
    end
    mid(); chk("oor_idle12", 64'(b12), 64'h0);

    // Ready gating during SETUP and WRITE
    go(); req_valid = 2'b01; req_addr = {4'd6, 4'd4}; req_data = {32'h6666_6666, 32'h4444_4444};
    mid(); chk("rg_ready0", 64'(r16), 64'h1);
    go(); req_valid = 2'b10;
    mid(); chk("rg_ready_setup", 64'(r16), 64'h0);
    mid(); chk("rg_ready_write", 64'(r16), 64'h0); chk("rg_lden", 64'(l16), 64'h0010);
    mid(); chk("rg_ready_hold", 64'(r16), 64'h2);
    go(); req_valid = '0;
    repeat (4) mid();

    // Reset dropped in the middle of the enable pulse
    go(); req_valid = 2'b01; req_addr = {4'd0, 4'd9}; req_data = {32'h0, 32'h9999_9999};
    mid(); chk("rm_ready0", 64'(r16), 64'h1);
    go(); req_valid = '0;
    go(); chk("rm_lden_pre", 64'(l16), 64'h0200);
    #1 rst_n = 1'b0;
    #1 chk("rm_lden_async16", 64'(l16), 64'h0); chk("rm_lden_async12", 64'(l12), 64'h0);
       chk("rm_busy_async", 64'(b16), 64'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    go(); req_valid = 2'b11; req_addr = {4'd11, 4'd10}; req_data = {32'hBBBB_0011, 32'hAAAA_0010};
    mid(); chk("rm_ready_after", 64'(r16), 64'h1);
    go(); req_valid = '0;
    mid();
    mid(); chk("rm_lden_after", 64'(l16), 64'h0400);
    repeat (3) mid();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ltch_rf_wr_ctrl.md
Name: ltch_rf_wr_ctrl

Overview:
- Write sequencer and arbiter for an array of DEPTH general latch entries, each DW bits, instantiated outside this block.
- Accepts write requests from REQ_NUM requesters and grants them round-robin.
- Stages the winning data in flops and drives each entry's latch enable as a one-cycle, glitch-free, registered one-hot pulse.
- Latch data is held stable before, during and after every enable pulse, so latch setup and hold are never violated.

Parameters:
- REQ_NUM, 2: number of write requesters, legal range 1..8.
- DEPTH, 16: number of latch entries.
- DW, 32: data width of each entry.
- AW, $clog2(DEPTH): address width, derived; do not override.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  REQ_NUM  per-requester write valid.
- req_ready  out  REQ_NUM  per-requester accept; a write transfers on valid&ready.
- req_addr  in  REQ_NUM*AW  packed addresses; requester i uses slice [i*AW +: AW].
- req_data  in  REQ_NUM*DW  packed write data; requester i uses slice [i*DW +: DW].
- ltch_lden  out  DEPTH  one-hot latch enables, driven directly from flops.
- ltch_dnxt  out  DW  shared latch data, driven directly from the data flop.
- busy  out  1  a write is in flight (state is not IDLE).
- busy_addr  out  AW  address of the in-flight write.

Behaviour:
- Reset values: state=IDLE; ltch_lden=0; ltch_dnxt=0; busy=0; busy_addr=0; round-robin pointer=REQ_NUM-1, so requester 0 has first priority.
- Latch contents are not reset.
- FSM states and transitions:
  - IDLE: go to SETUP on any accepted request.
  - SETUP: data and address flops hold the new write; ltch_lden=0; always go to WRITE.
  - WRITE: ltch_lden[addr_r]=1 for exactly one cycle; always go to HOLD.
  - HOLD: ltch_lden=0; data is still stable. Go to SETUP if a request is accepted this cycle, else go to IDLE.
- Accept window: IDLE or HOLD only.
  - In the window, req_ready[i]=1 only for the arbiter winner; all other ready bits are 0.
  - req_ready may depend combinationally on req_valid; req_valid must not depend on req_ready.
  - On accept: the data flop, address flop and pointer update at the same edge as the transition into SETUP.
- Throughput: one write every 3 cycles under back-to-back load.
- Latency: from the accept edge, ltch_lden rises 1 cycle later and falls 2 cycles later.
- Arbitration: round-robin. Priority starts at pointer+1 and wraps modulo REQ_NUM. The pointer updates to the granted index on accept only. No valid means no grant and no pointer change.
- Out-of-range address (addr >= DEPTH, possible when DEPTH is not a power of two):
  - the sequence runs normally, but ltch_lden stays all-zero;
  - the write is silently dropped and busy behaves as for a normal write.
- Requester protocol: req_valid, req_addr and req_data are held stable until ready. Dropping valid before ready is legal; no grant results.
- Reset asserted mid-sequence: ltch_lden clears immediately (asynchronously) and the FSM returns to IDLE. The partially written entry's content is undefined.
- Simulation-only assertions, excluded when FPGA_SOURCE or DISABLE_SV_ASSERTION is defined:
  - at most one bit of ltch_lden is set;
  - ltch_dnxt does not change in any cycle where ltch_lden is nonzero, or in the cycle after it;
  - no X on req_valid after reset; a violation calls $fatal.

Decomposition:
- Package ltch_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, WRITE, HOLD), 2 bits;
  - constant MAX_REQ_NUM=8.
- Sub-module ltch_rr_arb (parameter REQ_NUM):
  - inputs: req vector, pointer;
  - outputs: one-hot grant and encoded grant index;
  - purely combinational.
- The pointer, FSM, data flop and address flop remain in ltch_rf_wr_ctrl.

Test Plan:
- Single write: after reset, req0 writes addr=3, data=0xDEADBEEF.
  - Required: ready high in cycle 0; ltch_lden=0x0008 in cycle 2 only; ltch_dnxt=0xDEADBEEF in cycles 1-3; busy high in cycles 1-3.
- Contention: req0 and req1 held valid continuously, addresses 1 and 2.
  - Required: grants alternate 0,1,0,1 every 3 cycles; ltch_lden alternates 0x0002, 0x0004.
- Back-to-back from HOLD: req1 arrives while the FSM is in HOLD.
  - Required: accepted in HOLD; next ltch_lden pulse exactly 3 cycles after the previous pulse; no IDLE cycle in between.
- Out of range: DEPTH=12, write to addr=13.
  - Required: full SETUP/WRITE/HOLD sequence, ltch_lden=0 throughout, busy_addr=13.
- Reset mid-write: rst_n dropped during WRITE.
  - Required: ltch_lden=0 immediately, state=IDLE, pointer reset, so requester 0 wins the next arbitration.
- Ready gating: valid asserted during SETUP and during WRITE.
  - Required: ready=0 in both states; accepted in the following HOLD.
